// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the switch debounce block.
// Defaults assume a 50 MHz clock: 1 ms sample tick, 20 ms filter window.
package switch_debounce_pkg;

    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 20;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/switch_debounce_cell.sv
// One debounce channel: a tick-counted stability filter on a synchronized input,
// with registered rise/fall pulses aligned to the first cycle of the new level.
module switch_debounce_cell
    import switch_debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic sync_in,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W    = clog2_min1(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_rise;
    logic             r_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_clean <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // A match always wins, so a bounce back on the final tick is ignored.
            if (sync_in == r_clean) begin
                r_cnt <= '0;
            end else if (tick) begin
                if (r_cnt == CNT_LAST) begin
                    r_clean <= sync_in;
                    r_cnt   <= '0;
                    r_rise  <= sync_in;
                    r_fall  <= ~sync_in;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign clean = r_clean;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule

// File: rtl/nios_system_switch_debounce.sv
// Conditions raw board switches for the PIO in_port: per-channel 2-flop
// synchronizer, shared free-running sample prescaler, and one filter cell per channel.
module nios_system_switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int              N_CH         = 4,
    parameter int              TICK_DIV     = DEF_TICK_DIV,
    parameter int              STABLE_TICKS = DEF_STABLE_TICKS,
    parameter logic [N_CH-1:0] RESET_VAL    = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] sw_raw,
    output logic [N_CH-1:0] sw_clean,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall
);

    localparam int            PW         = clog2_min1(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic [PW-1:0]   r_presc;
    logic            w_tick;
    logic [N_CH-1:0] w_clean;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RESET_VAL;
            r_sync2 <= RESET_VAL;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // With TICK_DIV=1 the counter is stuck at 0 and the tick is permanently high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == PRESC_LAST);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        switch_debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_VAL    (RESET_VAL[i])
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (w_tick),
            .sync_in (r_sync2[i]),
            .clean   (w_clean[i]),
            .rise    (w_rise[i]),
            .fall    (w_fall[i])
        );
    end

    assign sw_clean = w_clean;
    assign sw_rise  = w_rise;
    assign sw_fall  = w_fall;

endmodule
